// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU multiply/divide datapath.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } md_state_e;

    localparam int MD_ITERS = 32;

endpackage

// File: rtl/mips_cpu_multdiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
module mips_cpu_multdiv
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        hi_en,
    output logic        lo_en
);

    md_state_e   state_q, state_d;
    logic        is_div_q, is_div_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] ma_q, ma_d;
    logic [31:0] mb_q, mb_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_e      op_e;
    logic        signed_op;
    logic [4:0]  bit_idx;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [63:0] prod_neg;

    always_comb begin
        op_e      = md_op_e'(op);
        signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
        bit_idx   = 5'd31 - count_q;
        rem_sh    = {acc_q[63:32], ma_q[bit_idx]};
        trial     = rem_sh - {1'b0, mb_q};
        prod_neg  = -acc_q;

        state_d  = state_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = (op_e == OP_DIV) || (op_e == OP_DIVU);
                    sa_d     = signed_op & a[31];
                    sb_d     = signed_op & b[31];
                    ma_d     = sa_d ? -a : a;
                    mb_d     = sb_d ? -b : b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    // quotient bits shift into acc[31:0], remainder lives in acc[63:32]
                    acc_d = trial[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                      : {trial[31:0], acc_q[30:0], 1'b1};
                end else begin
                    acc_d = {acc_q[62:0], 1'b0}
                          + (mb_q[bit_idx] ? {32'd0, ma_q} : 64'd0);
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'(MD_ITERS - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (mb_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = sa_q ? -ma_q : ma_q;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
                        hi_d = sa_q ? -acc_q[63:32] : acc_q[63:32];
                    end
                end else begin
                    {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_en  = done_q;
    assign lo_en  = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Self-checking bench for mips_cpu_multdiv: arithmetic reference model
// checked every cycle, plus literal results from hand calculation.
module tb_mips_cpu_multdiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, hi_en, lo_en;
    logic [31:0] hi_out, lo_out;

    int n_total = 0;
    int n_pass  = 0;
    bit en = 1'b0;

    mips_cpu_multdiv dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .hi_en  (hi_en),
        .lo_en  (lo_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] got,
                       input logic [71:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    endtask

    // Reference result {hi, lo} computed with plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy;
        int     q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_cnt = 0;

    // Timing model: result lands 33 edges after accept, idle after 34
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_res  <= model(op, a, b);
            end
        end else begin
            m_cnt  <= m_cnt + 1;
            m_done <= (m_cnt + 1 == 33);
            if (m_cnt + 1 == 33) {m_hi, m_lo} <= m_res;
            if (m_cnt + 1 == 34) m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (en)
            chk("cycle", {busy, done, hi_en, lo_en, hi_out, lo_out},
                {m_busy, m_done, m_done, m_done, m_hi, m_lo});
    end

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit inject);
        int lat;
        lat = 0;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a = $urandom;
                b = $urandom;
                op = 2'($urandom_range(0, 3));
            end
            if (inject && i == 10) begin
                start = 1'b1;
                op = 2'b11;
                a = 32'd9;
                b = 32'd3;
            end
            if (inject && i == 11) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({name, "_latency"}, 72'(lat), 72'd34);
        chk({name, "_result"}, {8'd0, hi_out, lo_out}, {8'd0, ehi, elo});
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {busy, done, hi_en, lo_en, hi_out, lo_out}, 72'd0);
        reset = 1'b0;
        en = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op("div_by0_neg", 2'b10, 32'hFFFF_FFF0, 32'd0,
               32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0);
        run_op("multu_ignore", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
        run_op("multu_mid", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0,
               32'h0B00_EA4E, 32'h242D_2080, 1'b0);

        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        a = 32'd1000;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_state", {busy, done, hi_out, lo_out}, 72'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 72'(ndone), 72'd0);

        run_op("div_after_abort", 2'b10, 32'd1000, 32'hFFFF_FFFD,
               32'd1, 32'hFFFF_FEB3, 1'b0);

        repeat (3) @(negedge clk);
        en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
